serial_addsub_unit: RTL and testbench

//  Parametrised multi-cycle two's-complement adder/subtractor, successor to the fixed 5-bit ripple subtractor.

---
 rtl/serial_addsub_if.sv | 26 ++
 rtl/serial_addsub_unit.sv | 92 +++++++++
 tb/tb_serial_addsub_unit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// Handshake and data bundle for serial_addsub_unit: requester drives start/sub/A/B,
// unit returns busy/done and the registered result with status flags.
interface serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic             Cout;
    logic             Overflow;
    logic             Zero;

    modport master (
        output start, sub, A, B,
        input  busy, done, Result, Cout, Overflow, Zero
    );

    modport slave (
        input  start, sub, A, B,
        output busy, done, Result, Cout, Overflow, Zero
    );
endinterface

// File: rtl/serial_addsub_unit.sv
// Multi-cycle two's-complement adder/subtractor: DIGIT bits per clock, LSB first,
// through one DIGIT-wide ripple slice, with start/busy/done handshake.
module serial_addsub_unit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic           clk,
    input logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [DIGIT:0]   w_sum;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_acc_next;

    // Shift-based accumulator update stays legal when DIGIT == WIDTH (acc >> WIDTH is 0).
    always_comb begin
        w_sum      = {1'b0, r_opa[DIGIT-1:0]} + {1'b0, r_opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
        w_cmsb     = r_opa[DIGIT-1] ^ r_opb[DIGIT-1] ^ w_sum[DIGIT-1];
        w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (r_state == RUN) begin
            r_opa   <= r_opa >> DIGIT;
            r_opb   <= r_opb >> DIGIT;
            r_acc   <= w_acc_next;
            r_carry <= w_sum[DIGIT];
            r_cnt   <= r_cnt + CW'(1);
            if (r_cnt == CW'(N - 1)) begin
                r_state  <= DONE;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_result <= w_acc_next;
                r_cout   <= w_sum[DIGIT];
                r_ovf    <= w_cmsb ^ w_sum[DIGIT];
                r_zero   <= (w_acc_next == '0);
            end
        end else begin
            // IDLE and DONE accept start identically, which gives back-to-back issue.
            r_done <= 1'b0;
            if (bus.start) begin
                r_state <= RUN;
                r_busy  <= 1'b1;
                r_opa   <= bus.A;
                r_opb   <= bus.B ^ {WIDTH{bus.sub}};
                r_carry <= bus.sub;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else begin
                r_state <= IDLE;
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.Result   = r_result;
    assign bus.Cout     = r_cout;
    assign bus.Overflow = r_ovf;
    assign bus.Zero     = r_zero;
endmodule

// File: tb/tb_serial_addsub_unit.sv
// Bench for serial_addsub_unit: 16/4 configuration with directed, random and handshake
// scenarios, plus exhaustive 5-bit runs for DIGIT=1 and DIGIT=5 against an arithmetic model.
module tb_serial_addsub_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_addsub_if #(.WIDTH(16)) b16 ();
    serial_addsub_if #(.WIDTH(5))  b5a ();
    serial_addsub_if #(.WIDTH(5))  b5b ();

    serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    serial_addsub_unit #(.WIDTH(5),  .DIGIT(1)) u5a (.clk(clk), .rst_n(rst_n), .bus(b5a));
    serial_addsub_unit #(.WIDTH(5),  .DIGIT(5)) u5b (.clk(clk), .rst_n(rst_n), .bus(b5b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned/signed arithmetic on integers.
    task automatic model(input int w, input int a, input int b, input bit s,
                         output int res, output bit c, output bit v, output bit z);
        int m, sa, sb, r;
        m  = 1 << w;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        if (s) begin
            c   = (a >= b);
            res = (a - b + m) % m;
            r   = sa - sb;
        end else begin
            c   = ((a + b) >= m);
            res = (a + b) % m;
            r   = sa + sb;
        end
        v = (r > m / 2 - 1) || (r < -(m / 2));
        z = (res == 0);
    endtask

    task automatic wait_done16(output int lat, output int bc);
        bc  = b16.busy ? 1 : 0;
        lat = 0;
        while (!b16.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (b16.busy) bc++;
        end
    endtask

    task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                           output int lat, output int bc);
        @(negedge clk);
        b16.A = a; b16.B = b; b16.sub = s; b16.start = 1'b1;
        @(posedge clk); #1;
        b16.start = 1'b0;
        b16.A = 16'($urandom);
        b16.B = 16'($urandom);
        b16.sub = ~s;
        wait_done16(lat, bc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({b16.busy, b16.done, b16.Cout, b16.Overflow, b16.Zero, b16.Result} !== 21'd0) begin
            errors++;
            $display("FAIL reset16: got %h expected 0",
                     {b16.busy, b16.done, b16.Cout, b16.Overflow, b16.Zero, b16.Result});
        end
        checks++;
        if ({b5a.busy, b5a.done, b5a.Cout, b5a.Overflow, b5a.Zero, b5a.Result} !== 10'd0) begin
            errors++;
            $display("FAIL reset5a: got %h expected 0",
                     {b5a.busy, b5a.done, b5a.Cout, b5a.Overflow, b5a.Zero, b5a.Result});
        end
        checks++;
        if ({b5b.busy, b5b.done, b5b.Cout, b5b.Overflow, b5b.Zero, b5b.Result} !== 10'd0) begin
            errors++;
            $display("FAIL reset5b: got %h expected 0",
                     {b5b.busy, b5b.done, b5b.Cout, b5b.Overflow, b5b.Zero, b5b.Result});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] ta[5] = '{16'h1234, 16'h0005, 16'h8000, 16'h7FFF, 16'hFFFF};
        logic [15:0] tb[5] = '{16'h0FFF, 16'h0007, 16'h0001, 16'h0001, 16'h0001};
        logic        ts[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        // {Cout, Overflow, Zero, Result}
        logic [18:0] te[5] = '{{3'b000, 16'h2233}, {3'b000, 16'hFFFE}, {3'b110, 16'h7FFF},
                               {3'b010, 16'h8000}, {3'b101, 16'h0000}};
        int lat, bc;
        for (int i = 0; i < 5; i++) begin
            do_op16(ta[i], tb[i], ts[i], lat, bc);
            checks++;
            if ({b16.Cout, b16.Overflow, b16.Zero, b16.Result} !== te[i]) begin
                errors++;
                $display("FAIL directed%0d: got %h expected %h", i,
                         {b16.Cout, b16.Overflow, b16.Zero, b16.Result}, te[i]);
            end
            checks++;
            if (lat != 4 || bc != 4) begin
                errors++;
                $display("FAIL directed_latency%0d: got lat=%0d busy=%0d expected lat=4 busy=4", i, lat, bc);
            end
        end
    endtask

    task automatic test_random16();
        int lat, bc, res;
        bit c, v, z;
        logic [15:0] a, b;
        logic s;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom_range(0, 1));
            model(16, int'(a), int'(b), s, res, c, v, z);
            do_op16(a, b, s, lat, bc);
            checks++;
            if ({b16.Cout, b16.Overflow, b16.Zero, b16.Result} !== {c, v, z, 16'(res)} || lat != 4) begin
                errors++;
                $display("FAIL random16 %h %s %h: got %h lat=%0d expected %h lat=4", a, s ? "-" : "+", b,
                         {b16.Cout, b16.Overflow, b16.Zero, b16.Result}, lat, {c, v, z, 16'(res)});
            end
        end
    endtask

    task automatic test_start_ignored();
        int lat, bc, res;
        bit c, v, z;
        model(16, 16'h4321, 16'h1111, 1'b1, res, c, v, z);
        @(negedge clk);
        b16.A = 16'h4321; b16.B = 16'h1111; b16.sub = 1'b1; b16.start = 1'b1;
        @(posedge clk); #1;
        b16.start = 1'b0;
        @(negedge clk);
        b16.A = 16'hAAAA; b16.B = 16'h5555; b16.sub = 1'b0; b16.start = 1'b1;
        @(negedge clk);
        b16.start = 1'b0;
        #6;
        wait_done16(lat, bc);
        lat = lat + 2;
        checks++;
        if ({b16.Cout, b16.Overflow, b16.Zero, b16.Result} !== {c, v, z, 16'(res)} || lat != 4) begin
            errors++;
            $display("FAIL start_ignored: got %h lat=%0d expected %h lat=4",
                     {b16.Cout, b16.Overflow, b16.Zero, b16.Result}, lat, {c, v, z, 16'(res)});
        end
        @(posedge clk); #1;
        checks++;
        if (b16.busy !== 1'b0 || b16.done !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_idle: got busy=%b done=%b expected 0 0", b16.busy, b16.done);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, res;
        bit c, v, z;
        model(16, 16'h00FF, 16'h0F01, 1'b0, res, c, v, z);
        do_op16(16'h00FF, 16'h0F01, 1'b0, lat, bc);
        checks++;
        if (b16.Result !== 16'(res) || lat != 4) begin
            errors++;
            $display("FAIL b2b_first: got %h lat=%0d expected %h lat=4", b16.Result, lat, 16'(res));
        end
        // still inside the DONE cycle: issue the next request now
        model(16, 16'h1000, 16'h2000, 1'b1, res, c, v, z);
        b16.A = 16'h1000; b16.B = 16'h2000; b16.sub = 1'b1; b16.start = 1'b1;
        @(posedge clk); #1;
        b16.start = 1'b0;
        checks++;
        if (b16.busy !== 1'b1 || b16.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", b16.busy, b16.done);
        end
        wait_done16(lat, bc);
        checks++;
        if ({b16.Cout, b16.Overflow, b16.Zero, b16.Result} !== {c, v, z, 16'(res)} || lat != 4) begin
            errors++;
            $display("FAIL b2b_second: got %h lat=%0d expected %h lat=4",
                     {b16.Cout, b16.Overflow, b16.Zero, b16.Result}, lat, {c, v, z, 16'(res)});
        end
    endtask

    task automatic test_reset_midrun();
        int lat, bc, res, seen;
        bit c, v, z;
        do_op16(16'h7000, 16'h7000, 1'b0, lat, bc);
        @(negedge clk);
        b16.A = 16'h0123; b16.B = 16'h0456; b16.sub = 1'b0; b16.start = 1'b1;
        @(posedge clk); #1;
        b16.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({b16.busy, b16.done, b16.Cout, b16.Overflow, b16.Zero, b16.Result} !== 21'd0) begin
            errors++;
            $display("FAIL reset_midrun: got %h expected 0",
                     {b16.busy, b16.done, b16.Cout, b16.Overflow, b16.Zero, b16.Result});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (b16.done || b16.busy) seen++;
        end
        checks++;
        if (seen != 0 || b16.Result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_abort: got activity=%0d result=%h expected 0 0", seen, b16.Result);
        end
        model(16, 16'h0123, 16'h0456, 1'b0, res, c, v, z);
        do_op16(16'h0123, 16'h0456, 1'b0, lat, bc);
        checks++;
        if ({b16.Cout, b16.Overflow, b16.Zero, b16.Result} !== {c, v, z, 16'(res)} || lat != 4) begin
            errors++;
            $display("FAIL reset_recover: got %h lat=%0d expected %h lat=4",
                     {b16.Cout, b16.Overflow, b16.Zero, b16.Result}, lat, {c, v, z, 16'(res)});
        end
    endtask

    task automatic test_exhaustive5();
        int res, la, lb;
        bit c, v, z;
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                for (int s = 0; s < 2; s++) begin
                    model(5, a, b, s[0], res, c, v, z);
                    @(negedge clk);
                    b5a.A = 5'(a); b5a.B = 5'(b); b5a.sub = s[0]; b5a.start = 1'b1;
                    b5b.A = 5'(a); b5b.B = 5'(b); b5b.sub = s[0]; b5b.start = 1'b1;
                    @(posedge clk); #1;
                    b5a.start = 1'b0; b5b.start = 1'b0;
                    b5a.A = 5'($urandom); b5b.B = 5'($urandom);
                    la = -1; lb = -1;
                    for (int cyc = 1; cyc <= 10 && (la < 0 || lb < 0); cyc++) begin
                        @(posedge clk); #1;
                        if (b5a.done && la < 0) la = cyc;
                        if (b5b.done && lb < 0) lb = cyc;
                    end
                    checks++;
                    if ({b5a.Cout, b5a.Overflow, b5a.Zero, b5a.Result} !== {c, v, z, 5'(res)} || la != 5) begin
                        errors++;
                        $display("FAIL exh_d1 %0d %0d sub=%0d: got %b lat=%0d expected %b lat=5", a, b, s,
                                 {b5a.Cout, b5a.Overflow, b5a.Zero, b5a.Result}, la, {c, v, z, 5'(res)});
                    end
                    checks++;
                    if ({b5b.Cout, b5b.Overflow, b5b.Zero, b5b.Result} !== {c, v, z, 5'(res)} || lb != 1) begin
                        errors++;
                        $display("FAIL exh_d5 %0d %0d sub=%0d: got %b lat=%0d expected %b lat=1", a, b, s,
                                 {b5b.Cout, b5b.Overflow, b5b.Zero, b5b.Result}, lb, {c, v, z, 5'(res)});
                    end
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        b16.start = 1'b0; b16.sub = 1'b0; b16.A = '0; b16.B = '0;
        b5a.start = 1'b0; b5a.sub = 1'b0; b5a.A = '0; b5a.B = '0;
        b5b.start = 1'b0; b5b.sub = 1'b0; b5b.A = '0; b5b.B = '0;
        test_reset();
        test_directed();
        test_random16();
        test_start_ignored();
        test_back_to_back();
        test_reset_midrun();
        test_exhaustive5();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
